// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: state encoding and
// default datapath width.
package pipe_ctrl_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/sat_counter.sv
// Enabled up-counter that holds at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage sequencer: issues one req/ack memory transaction per EX/MEM load
// or store, stalls the front end and bubbles MEM/WB until it completes.
module mem_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TO_W        = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              stall_o,
  output logic              memwb_bubble_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic [31:0]       stall_cnt_o,
  output logic [1:0]        dbg_state_o
);

  // Handshake: mem_req_o rises with the request fields and stays high with
  // them unchanged until the cycle mem_ack_i is seen (or the timeout fires);
  // the ack is a one-cycle pulse with read data valid in that same cycle.

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  mem_state_e        r_state;
  mem_state_e        w_next;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_req;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic w_memop;
  logic w_stall;
  logic w_issue;
  logic w_ack_take;
  logic w_timeout;

  assign w_memop = memread_i | memwrite_i;

  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_issue    = 1'b0;
    w_ack_take = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memop) begin
          w_stall = 1'b1;
          w_issue = 1'b1;
          w_next  = WAIT;
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        // Ack is checked first so an ack on the last allowed cycle still wins.
        if (mem_ack_i) begin
          w_ack_take = 1'b1;
          w_next     = DONE;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_to_cnt <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_req    <= 1'b1;
        r_we     <= memwrite_i;
        r_addr   <= addr_i;
        r_wdata  <= wdata_i;
        r_to_cnt <= '0;
      end
      if (r_state == WAIT) begin
        r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
      end
      if (w_ack_take) begin
        r_req <= 1'b0;
        if (!r_we) begin
          r_rdata <= mem_rdata_i;
        end
      end
      if (w_timeout) begin
        r_req   <= 1'b0;
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
    end
  end

  sat_counter #(.W(32)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (w_stall),
    .cnt_o (stall_cnt_o)
  );

  assign mem_req_o      = r_req;
  assign mem_we_o       = r_we;
  assign mem_addr_o     = r_addr;
  assign mem_wdata_o    = r_wdata;
  assign stall_o        = w_stall;
  assign memwb_bubble_o = w_stall;
  assign rdata_o        = r_rdata;
  assign err_o          = r_err;
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed and randomized bench for mem_stall_ctrl against a per-transaction
// timeline model (stall length, request window, captured data, sticky error).
module tb_mem_stall_ctrl;

  localparam int DW = 32;
  localparam int TO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          memread, memwrite, mem_ack;
  logic [DW-1:0] addr_in, wdata_in, mem_rdata;
  logic          mem_req, mem_we, stall, bubble, err;
  logic [DW-1:0] mem_addr, mem_wdata, rdata;
  logic [31:0]   stall_cnt;
  logic [1:0]    dbg_state;

  mem_stall_ctrl #(.DATA_W(DW), .TO_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .memread_i      (memread),
    .memwrite_i     (memwrite),
    .addr_i         (addr_in),
    .wdata_i        (wdata_in),
    .mem_ack_i      (mem_ack),
    .mem_rdata_i    (mem_rdata),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .stall_o        (stall),
    .memwb_bubble_o (bubble),
    .rdata_o        (rdata),
    .err_o          (err),
    .stall_cnt_o    (stall_cnt),
    .dbg_state_o    (dbg_state)
  );

  // scoreboard state
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_cnt;
  logic [31:0] exp_rdata;
  logic        exp_err;
  int          exp_issues = 0;
  int          issues = 0;
  logic        prev_req = 1'b0;

  // count request rising edges to catch re-issues
  always @(posedge clk) begin
    #2;
    if (mem_req && !prev_req) issues++;
    prev_req = mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: idle cycles with a possible spurious ack
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      memread   = 1'b0;
      memwrite  = 1'b0;
      addr_in   = $urandom;
      wdata_in  = $urandom;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #1;
      check1("idle_stall", stall, 1'b0);
      check1("idle_req", mem_req, 1'b0);
      check32("idle_rdata", rdata, exp_rdata);
      check1("idle_err", err, exp_err);
      check32("idle_state", 32'(dbg_state), 32'd0);
      check32("idle_cnt", stall_cnt, exp_cnt);
    end
  endtask

  // driver: one EX/MEM memory op held until the pipeline is released.
  // k = ack cycle counted from first-seen cycle; outside 1..TO means no ack.
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int k, input logic [31:0] rdat);
    logic        acked;
    int          ke;
    logic [31:0] a_exp;
    acked = (k >= 1) && (k <= TO);
    ke    = acked ? k : TO;
    a_exp = 32'd0;
    exp_q.push_back(addr);
    for (int c = 0; c <= ke + 1; c++) begin
      @(negedge clk);
      memread   = rd;
      memwrite  = wr;
      addr_in   = addr;
      wdata_in  = wdata;
      mem_ack   = (acked && c == k) ? 1'b1 :
                  (c == ke + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = (acked && c == k) ? rdat : $urandom;
      #1;
      check1("stall", stall, c <= ke);
      check1("bubble", bubble, c <= ke);
      check32("stall_cnt", stall_cnt, exp_cnt);
      if (c <= ke) exp_cnt++;
      if (c == 0) check32("state_idle", 32'(dbg_state), 32'd0);
      if (c >= 1) check1("req", mem_req, c <= ke);
      if (c == 1) a_exp = exp_q.pop_front();
      if (c >= 1 && c <= ke) begin
        check32("req_addr", mem_addr, a_exp);
        check1("req_we", mem_we, wr);
        if (wr) check32("req_wdata", mem_wdata, wdata);
        check32("state_wait", 32'(dbg_state), 32'd1);
      end
      if (c == ke + 1) begin
        exp_issues++;
        if (!acked) begin
          exp_rdata = 32'd0;
          exp_err   = 1'b1;
        end else if (!wr) begin
          exp_rdata = rdat;
        end
        check32("done_rdata", rdata, exp_rdata);
        check1("done_err", err, exp_err);
        check32("state_done", 32'(dbg_state), 32'd2);
      end
    end
  endtask

  initial begin
    logic [1:0] sel;
    rst_n = 1'b0;
    memread = 1'b0; memwrite = 1'b0; mem_ack = 1'b0;
    addr_in = '0; wdata_in = '0; mem_rdata = '0;
    exp_cnt = 32'd0; exp_rdata = 32'd0; exp_err = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    #1;
    check1("rst_req", mem_req, 1'b0);
    check1("rst_we", mem_we, 1'b0);
    check32("rst_addr", mem_addr, 32'd0);
    check32("rst_wdata", mem_wdata, 32'd0);
    check32("rst_rdata", rdata, 32'd0);
    check1("rst_err", err, 1'b0);
    check32("rst_cnt", stall_cnt, 32'd0);
    check1("rst_stall", stall, 1'b0);
    memread = 1'b1;
    #1;
    check1("rst_stall_op", stall, 1'b1);
    memread = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    idle(2);
    do_op(1'b1, 1'b0, 32'h100, $urandom, 3, 32'h1234_5678);
    idle(1);
    do_op(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 1, $urandom);
    idle(1);
    do_op(1'b1, 1'b0, 32'h80, $urandom, 0, $urandom);
    idle(1);
    do_op(1'b1, 1'b0, 32'h84, $urandom, TO, 32'hA5A5_0001);
    do_op(1'b0, 1'b1, 32'h88, 32'h0BAD_BEEF, 2, $urandom);
    idle(1);
    do_op(1'b1, 1'b0, 32'h10, $urandom, 1, 32'h1111_0010);
    do_op(1'b1, 1'b0, 32'h14, $urandom, 1, 32'h2222_0014);
    idle(3);
    do_op(1'b1, 1'b1, 32'h50, 32'h5555_AAAA, 2, $urandom);
    idle(1);

    // reset in the middle of WAIT
    @(negedge clk);
    memread = 1'b1; memwrite = 1'b0; addr_in = 32'h200; mem_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      mem_ack = 1'b0;
    end
    #2;
    rst_n   = 1'b0;
    memread = 1'b0;
    #1;
    exp_issues++;
    check1("mid_rst_req", mem_req, 1'b0);
    check1("mid_rst_stall", stall, 1'b0);
    check1("mid_rst_err", err, 1'b0);
    check32("mid_rst_cnt", stall_cnt, 32'd0);
    check32("mid_rst_state", 32'(dbg_state), 32'd0);
    exp_cnt = 32'd0; exp_rdata = 32'd0; exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    do_op(1'b1, 1'b0, 32'h204, $urandom, 2, 32'h7777_0204);
    idle(1);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      sel = 2'($urandom_range(1, 3));
      do_op(sel[0], sel[1], $urandom & 32'hFFFF_FFFC, $urandom,
            $urandom_range(0, TO + 2), $urandom);
      idle($urandom_range(0, 2));
    end
    idle(1);
    check32("req_issues", 32'(issues), 32'(exp_issues));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
- Sequences the MEM stage of the 5-stage RISC-V pipeline against a variable-latency data memory that uses a req/ack handshake.
- Detects a load or store held in EX/MEM, issues one memory transaction, and stalls the front of the pipeline until the transaction completes.
- Forces bubbles into MEM/WB while stalled, and captures load data that MEM/WB latches on the release cycle.
- Also provides a sticky timeout error flag and a stall-cycle performance counter.

Parameters:
- DATA_W, 32: data and address width.
- TO_W, 8: width of the timeout counter.
- TIMEOUT_CYC, 255: number of WAIT cycles without ack before the transaction is aborted. Must be less than or equal to 2^TO_W - 1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- memread_i  in  1  EX/MEM load flag.
- memwrite_i  in  1  EX/MEM store flag.
- addr_i  in  DATA_W  EX/MEM ALU result (byte address).
- wdata_i  in  DATA_W  EX/MEM store data.
- mem_ack_i  in  1  memory completion pulse; read data is valid in the same cycle.
- mem_rdata_i  in  DATA_W  memory read data.
- mem_req_o  out  1  registered request; held until ack or timeout.
- mem_we_o  out  1  registered write enable for the current request.
- mem_addr_o  out  DATA_W  registered request address.
- mem_wdata_o  out  DATA_W  registered request write data.
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- memwb_bubble_o  out  1  forces MEM/WB regwrite and memtoreg to 0.
- rdata_o  out  DATA_W  captured load data, fed to MEM/WB memdata input.
- err_o  out  1  sticky timeout flag.
- stall_cnt_o  out  32  saturating count of stall cycles.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, err_o, stall_cnt_o and the timeout counter all go to 0.
  - stall_o and memwb_bubble_o read 0 unless an operation is present in IDLE.
  - Reset mid-transaction drops mem_req_o immediately; the memory side must tolerate an abandoned request.
- Definitions:
  - memop = memread_i | memwrite_i.
  - If memread_i and memwrite_i are both 1, the operation is treated as a store.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - With memop=0, the block stays in IDLE and stall_o=0.
  - With memop=1:
    - stall_o=1 combinationally.
    - On the clock edge: mem_req_o<=1, mem_we_o<=memwrite_i, mem_addr_o<=addr_i, mem_wdata_o<=wdata_i, timeout counter<=0, and the state moves to WAIT.
  - mem_ack_i seen in IDLE or DONE is ignored.
- WAIT:
  - stall_o=1 throughout.
  - Request outputs are held stable.
  - The timeout counter increments each cycle.
  - mem_ack_i=1:
    - rdata_o<=mem_rdata_i for a load; for a store, rdata_o keeps its previous value.
    - mem_req_o<=0, and the state moves to DONE.
  - Ack and timeout in the same cycle: ack wins and err_o is not set.
  - Counter reaches TIMEOUT_CYC with no ack: err_o<=1, rdata_o<=0, mem_req_o<=0, and the state moves to DONE.
- DONE:
  - stall_o=0 and the pipeline advances.
  - MEM/WB latches rdata_o.
  - The state returns to IDLE unconditionally, so the still-visible EX/MEM operation is never re-issued.
  - An operation entering EX/MEM on this edge is evaluated in IDLE on the next cycle.
- memwb_bubble_o = stall_o.
- Latency:
  - An operation first seen in cycle t with ack in cycle t+k (k≥1) gives stall_o=1 for cycles t..t+k.
  - DONE falls in cycle t+k+1.
  - Minimum stall is 2 cycles.
- Back-to-back memory operations each pay the full sequence; there is no overlap.
- stall_cnt_o increments on every cycle with stall_o=1 and saturates at 32'hFFFF_FFFF.
- err_o stays 1 until reset.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding constants: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - DATA_W default.
- Sub-module sat_counter (parameterised width, enable, saturate-at-max) is used for stall_cnt_o.
- The FSM, request registers and timeout counter stay inline.

Test Plan:
- Load at addr 0x100 with ack 3 cycles after req, data 0x12345678:
  - mem_req_o high for 3 cycles with addr 0x100 and we=0.
  - stall_o high for 4 cycles.
  - rdata_o=0x12345678 in DONE.
  - stall_cnt_o=4.
- Store of 0xCAFEF00D to 0x40 with ack on the first req cycle:
  - mem_we_o=1 and mem_wdata_o=0xCAFEF00D.
  - 2 stall cycles.
  - err_o=0.
- No ack with TIMEOUT_CYC=4:
  - err_o=1 after 4 WAIT cycles.
  - rdata_o=0 and the FSM passes through DONE back to IDLE.
  - err_o remains 1 across later successful operations.
- Two consecutive loads (0x10, then 0x14), each acked after 1 cycle:
  - Two distinct requests with correct addresses.
  - No re-issue of 0x10 in DONE.
  - 4 total stall cycles.
- Reset asserted during WAIT:
  - mem_req_o, stall_o, err_o and stall_cnt_o all read 0 immediately (asynchronously).
  - After release, a new load completes normally.
- Spurious mem_ack_i in IDLE, and memread_i=memwrite_i=1:
  - The spurious ack causes no state change.
  - The dual-flag operation issues a store (mem_we_o=1).
